// File: rtl/ssd_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment vectors are {dp,g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam seg_t HEX_SEG [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_7segment.sv
// Combinational hex nibble to active-low segment pattern.
// The table leaves bit 7 high; the decimal point overrides it.
module hex_to_7segment
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output seg_t       seg
);

  always_comb begin
    seg    = HEX_SEG[hex];
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// NUM_DIGITS-way scanned seven-segment driver with PWM dimming.
// Optional leading-zero blanking: define SSD_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int REFRESH_RATE    = 80,
  parameter int BRIGHT_BITS     = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   commons,
  output seg_t                    segments,
  output logic                    frame_start
);

  localparam int DIGIT_TICKS =
    CLOCK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [BRIGHT_BITS-1:0]  pwm_cnt;
  logic                    started;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;

  logic       last_tick;
  logic       wrap;
  logic       fs;
  logic [3:0] nib;
  logic       cur_dp;
  logic       cur_en;
  logic       pwm_on;
  logic       blank;
  seg_t       enc;

  assign last_tick = presc == PW'(DIGIT_TICKS - 1);
  assign wrap      = last_tick && (idx == IW'(NUM_DIGITS - 1));
  // The clock after reset release opens frame 0 with the counters held.
  assign fs        = !started || wrap;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc       <= '0;
      idx         <= '0;
      pwm_cnt     <= '0;
      started     <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
    end else begin
      started <= 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (started) begin
        if (last_tick) begin
          presc <= '0;
          idx   <= wrap ? '0 : idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      if (fs) begin
        snap_digits <= digits;
        snap_dp     <= dp;
        snap_en     <= digit_en;
      end
    end
  end

  assign nib    = snap_digits[idx*4 +: 4];
  assign cur_dp = snap_dp[idx];
  assign cur_en = snap_en[idx];
  assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = (idx != '0) && (nib == 4'h0) && !cur_dp;
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if (j > int'(idx) && snap_en[j] &&
          snap_digits[4*j +: 4] != 4'h0)
        blank = 1'b0;
    end
  end
`else
  assign blank = 1'b0;
`endif

  hex_to_7segment u_hex (
    .hex (nib),
    .dp  (cur_dp),
    .seg (enc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      commons     <= '0;
      segments    <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fs;
      if (pwm_on && cur_en && !blank) begin
        commons  <= NUM_DIGITS'(1) << idx;
        segments <= enc;
      end else begin
        commons  <= '0;
        segments <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares against the DUT ports.
module tb_seven_segment_scan_controller;

  logic        clock;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [3:0]  commons;
  logic [7:0]  segments;
  logic        frame_start;

  seven_segment_scan_controller #(
    .NUM_DIGITS      (4),
    .CLOCK_FREQUENCY (800),
    .REFRESH_RATE    (50),
    .BRIGHT_BITS     (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .digits      (digits),
    .dp          (dp),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .commons     (commons),
    .segments    (segments),
    .frame_start (frame_start)
  );

  typedef struct {
    int         cyc;
    logic [3:0] com;
    logic [7:0] seg;
    logic       fs;
    bit         pwm;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   lit_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (commons != 4'b0) lit_cnt = lit_cnt + 1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      bit   ok;
      e = q.pop_front();
      n_chk = n_chk + 1;
      if (e.cyc != cyc) begin
        ok = 1'b0;
      end else if (e.pwm) begin
        ok = ((commons === e.com && segments === e.seg) ||
              (commons === 4'b0 && segments === 8'hFF)) &&
             frame_start === e.fs;
      end else begin
        ok = commons === e.com && segments === e.seg &&
             frame_start === e.fs;
      end
      if (!ok) begin
        n_fail = n_fail + 1;
        $display("FAIL cyc%0d(exp@%0d): got com=%b seg=%h fs=%b, need com=%b seg=%h fs=%b%s",
                 cyc, e.cyc, commons, segments, frame_start,
                 e.com, e.seg, e.fs, e.pwm ? " or dark" : "");
      end
    end
  end

  task automatic push(int c, logic [3:0] com, logic [7:0] seg,
                      logic fs, bit pwm);
    exp_t e;
    e.cyc = c;
    e.com = com;
    e.seg = seg;
    e.fs  = fs;
    e.pwm = pwm;
    q.push_back(e);
  endtask

  // One 16-clock frame whose snapshot edge is cycle b.
  task automatic push_frame(int b, logic [7:0] s0, logic [7:0] s1,
                            logic [7:0] s2, logic [7:0] s3,
                            logic [3:0] en, bit pwm);
    for (int k = 0; k < 16; k++) begin
      int         d;
      logic [7:0] s;
      logic [3:0] oh;
      d  = k / 4;
      s  = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
      oh = 4'b0001 << d;
      if (en[d]) push(b + 1 + k, oh, s, k == 15, pwm);
      else       push(b + 1 + k, 4'b0, 8'hFF, k == 15, pwm);
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int b;
    int b2;
    int l0;
    int l1;
    reset_n    = 1'b0;
    digits     = 16'h12AF;
    dp         = 4'b0000;
    digit_en   = 4'b1111;
    brightness = 4'hF;

    @(posedge clock);
    #1;
    for (int k = 1; k <= 4; k++) push(cyc + k, 4'b0, 8'hFF, 1'b0, 1'b0);
    wait_cyc(cyc + 4);
    reset_n = 1'b1;
    b = cyc + 1;

    push(b, 4'b0, 8'hFF, 1'b1, 1'b0);
    push_frame(b,      8'h8E, 8'h88, 8'hA4, 8'hF9, 4'b1111, 1'b0);
    push_frame(b + 16, 8'h8E, 8'h88, 8'hA4, 8'hF9, 4'b1111, 1'b0);

    wait_cyc(b + 22);
    digits = 16'h0000;
    push_frame(b + 32, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111, 1'b0);

    wait_cyc(b + 40);
    digits   = 16'h12AF;
    digit_en = 4'b1011;
    dp       = 4'b0001;
    push_frame(b + 48, 8'h0E, 8'h88, 8'hFF, 8'hF9, 4'b1011, 1'b0);

    wait_cyc(b + 56);
    digit_en = 4'b1111;
    dp       = 4'b0000;
    for (int f = 0; f < 4; f++)
      push_frame(b + 64 + 16 * f, 8'h8E, 8'h88, 8'hA4, 8'hF9,
                 4'b1111, 1'b1);

    wait_cyc(b + 64);
    brightness = 4'h4;
    @(negedge clock);
    #1;
    l0 = lit_cnt;

    wait_cyc(b + 128);
    brightness = 4'h0;
    push_frame(b + 128, 8'h8E, 8'h88, 8'hA4, 8'hF9, 4'b0000, 1'b0);
    @(negedge clock);
    #1;
    l1 = lit_cnt;
    n_chk = n_chk + 1;
    if (l1 - l0 != 16) begin
      n_fail = n_fail + 1;
      $display("FAIL pwm_duty: lit clocks=%0d of 64, need 16", l1 - l0);
    end

    wait_cyc(b + 136);
    digits = 16'h0070;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    push_frame(b + 144, 8'hC0, 8'hF8, 8'hC0, 8'hC0, 4'b0011, 1'b0);
`else
    push_frame(b + 144, 8'hC0, 8'hF8, 8'hC0, 8'hC0, 4'b1111, 1'b0);
`endif
    wait_cyc(b + 144);
    brightness = 4'hF;

    wait_cyc(b + 166);
    reset_n = 1'b0;
    for (int k = 7; k <= 9; k++)
      push(b + 160 + k, 4'b0, 8'hFF, 1'b0, 1'b0);
    wait_cyc(b + 169);
    digits  = 16'h12AF;
    reset_n = 1'b1;
    b2 = cyc + 1;
    push(b2, 4'b0, 8'hFF, 1'b1, 1'b0);
    push_frame(b2, 8'h8E, 8'h88, 8'hA4, 8'hF9, 4'b1111, 1'b0);

    wait_cyc(b2 + 16);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clock);
    n_chk = n_chk + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
